// File: rtl/ysyx_25040129_axi_pkg.sv
// ysyx_25040129 AXI front end: shared types and AXI constants.
// Imported by the arbiter, its bus interface and the bench.
package ysyx_25040129_axi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AWW,
        S_B
    } state_e;

    localparam int ID_W = 4;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [ID_W-1:0] ID_IFU = 4'd0;
    localparam logic [ID_W-1:0] ID_LSU = 4'd1;

    localparam logic [2:0] SIZE_WORD = 3'd2;

    function automatic logic resp_err(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/ysyx_25040129_axi_arbiter_if.sv
// ysyx_25040129 core AXI4 master port (io_master_*).
// master = arbiter side, slave = fabric / memory model side.
interface ysyx_25040129_axi_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    import ysyx_25040129_axi_pkg::*;

    logic              awvalid;
    logic              awready;
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;

    logic                awvalid_unused_guard;
    logic              wvalid;
    logic              wready;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic              wlast;

    logic              bvalid;
    logic              bready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;

    logic              arvalid;
    logic              arready;
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;

    logic              rvalid;
    logic              rready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;

    assign awvalid_unused_guard = 1'b0;

    modport master (
        output awvalid, awid, awaddr, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bid, bresp,
        output bready,
        output arvalid, arid, araddr, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rid, rdata, rresp, rlast,
        output rready
    );

    modport slave (
        input  awvalid, awid, awaddr, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bid, bresp,
        input  bready,
        input  arvalid, arid, araddr, arlen, arsize, arburst,
        output arready,
        output rvalid, rid, rdata, rresp, rlast,
        input  rready
    );

endinterface

// File: rtl/ysyx_25040129_axi_arbiter.sv
// ysyx_25040129 AXI arbiter: serialises IFU refills and LSU accesses
// onto the single io_master port, one transaction outstanding.
module ysyx_25040129_axi_arbiter
    import ysyx_25040129_axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    input  logic [7:0]          ifu_len,
    output logic                ifu_rvalid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_rlast,
    output logic                ifu_rerr,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic                lsu_wen,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [2:0]          lsu_size,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rsp_rdata,
    output logic                lsu_rsp_err,

    ysyx_25040129_axi_arbiter_if.master io_master
);

    state_e              state_q, state_d;
    logic                owner_lsu_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          len_q;
    logic [2:0]          size_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;

    logic grant_lsu, grant_ifu;
    logic unused_ok;

    // Held off during reset so nothing is accepted on the reset edge.
    assign grant_lsu = (state_q == S_IDLE) && !reset && lsu_req_valid;
    assign grant_ifu = (state_q == S_IDLE) && !reset && !lsu_req_valid
                       && ifu_req_valid;

    assign unused_ok = ^{io_master.bid, io_master.rid,
                         io_master.rresp[0], io_master.bresp[0]};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            owner_lsu_q <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            if (grant_lsu) begin
                owner_lsu_q <= 1'b1;
                addr_q      <= lsu_addr;
                len_q       <= 8'd0;
                size_q      <= lsu_size;
                wdata_q     <= lsu_wdata;
                wstrb_q     <= lsu_wstrb;
            end else if (grant_ifu) begin
                owner_lsu_q <= 1'b0;
                addr_q      <= ifu_addr;
                len_q       <= ifu_len;
                size_q      <= SIZE_WORD;
                wdata_q     <= '0;
                wstrb_q     <= '0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;

        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        ifu_rvalid    = 1'b0;
        ifu_rdata     = '0;
        ifu_rlast     = 1'b0;
        ifu_rerr      = 1'b0;
        lsu_rsp_valid = 1'b0;
        lsu_rsp_rdata = '0;
        lsu_rsp_err   = 1'b0;

        io_master.awvalid = 1'b0;
        io_master.awid    = '0;
        io_master.awaddr  = '0;
        io_master.awlen   = '0;
        io_master.awsize  = '0;
        io_master.awburst = '0;
        io_master.wvalid  = 1'b0;
        io_master.wdata   = '0;
        io_master.wstrb   = '0;
        io_master.wlast   = 1'b0;
        io_master.bready  = 1'b0;
        io_master.arvalid = 1'b0;
        io_master.arid    = '0;
        io_master.araddr  = '0;
        io_master.arlen   = '0;
        io_master.arsize  = '0;
        io_master.arburst = '0;
        io_master.rready  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                ifu_req_ready = grant_ifu;
                lsu_req_ready = grant_lsu;
                if (grant_lsu)
                    state_d = lsu_wen ? S_AWW : S_AR;
                else if (grant_ifu)
                    state_d = S_AR;
            end
            S_AR: begin
                io_master.arvalid = 1'b1;
                io_master.arid    = owner_lsu_q ? ID_LSU : ID_IFU;
                io_master.araddr  = addr_q;
                io_master.arlen   = len_q;
                io_master.arsize  = size_q;
                io_master.arburst = BURST_INCR;
                if (io_master.arready)
                    state_d = S_R;
            end
            S_R: begin
                io_master.rready = 1'b1;
                if (io_master.rvalid) begin
                    if (owner_lsu_q) begin
                        lsu_rsp_valid = 1'b1;
                        lsu_rsp_rdata = io_master.rdata;
                        lsu_rsp_err   = resp_err(io_master.rresp);
                    end else begin
                        ifu_rvalid = 1'b1;
                        ifu_rdata  = io_master.rdata;
                        ifu_rlast  = io_master.rlast;
                        ifu_rerr   = resp_err(io_master.rresp);
                    end
                    if (io_master.rlast)
                        state_d = S_IDLE;
                end
            end
            S_AWW: begin
                io_master.awvalid = !aw_done_q;
                io_master.awid    = ID_LSU;
                io_master.awaddr  = addr_q;
                io_master.awlen   = 8'd0;
                io_master.awsize  = size_q;
                io_master.awburst = BURST_INCR;
                io_master.wvalid  = !w_done_q;
                io_master.wdata   = wdata_q;
                io_master.wstrb   = wstrb_q;
                io_master.wlast   = 1'b1;
                aw_done_d = aw_done_q || io_master.awready;
                w_done_d  = w_done_q || io_master.wready;
                // Both channels may finish together or in either order.
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = S_B;
                end
            end
            S_B: begin
                io_master.bready = 1'b1;
                if (io_master.bvalid) begin
                    lsu_rsp_valid = 1'b1;
                    lsu_rsp_err   = resp_err(io_master.bresp);
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ysyx_25040129_axi_arbiter.sv
// Directed bench for the ysyx_25040129 AXI arbiter; the bench plays the
// AXI slave by hand and checks every client and bus output.
module tb_ysyx_25040129_axi_arbiter;
    import ysyx_25040129_axi_pkg::*;

    logic        clock = 1'b0;
    logic        reset;

    logic        ifu_req_valid, ifu_req_ready;
    logic [31:0] ifu_addr;
    logic [7:0]  ifu_len;
    logic        ifu_rvalid, ifu_rlast, ifu_rerr;
    logic [31:0] ifu_rdata;

    logic        lsu_req_valid, lsu_req_ready, lsu_wen;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rsp_rdata;
    logic [2:0]  lsu_size;
    logic [3:0]  lsu_wstrb;
    logic        lsu_rsp_valid, lsu_rsp_err;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    ysyx_25040129_axi_arbiter_if bus ();

    ysyx_25040129_axi_arbiter dut (
        .clock         (clock),
        .reset         (reset),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_addr      (ifu_addr),
        .ifu_len       (ifu_len),
        .ifu_rvalid    (ifu_rvalid),
        .ifu_rdata     (ifu_rdata),
        .ifu_rlast     (ifu_rlast),
        .ifu_rerr      (ifu_rerr),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_wen       (lsu_wen),
        .lsu_addr      (lsu_addr),
        .lsu_size      (lsu_size),
        .lsu_wdata     (lsu_wdata),
        .lsu_wstrb     (lsu_wstrb),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_rdata (lsu_rsp_rdata),
        .lsu_rsp_err   (lsu_rsp_err),
        .io_master     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic quiet(input string t);
        chk({t, ".arvalid"}, 32'(bus.arvalid), 0);
        chk({t, ".awvalid"}, 32'(bus.awvalid), 0);
        chk({t, ".wvalid"},  32'(bus.wvalid), 0);
        chk({t, ".rready"},  32'(bus.rready), 0);
        chk({t, ".bready"},  32'(bus.bready), 0);
        chk({t, ".ifu_rv"},  32'(ifu_rvalid), 0);
        chk({t, ".lsu_rv"},  32'(lsu_rsp_valid), 0);
    endtask

    // Four-beat IFU refill; err_beat selects the beat answered SLVERR.
    task automatic ifu_burst(input logic [31:0] a, input int err_beat);
        ifu_addr      = a;
        ifu_len       = 8'd3;
        ifu_req_valid = 1'b1;
        #1;
        chk("ifu.req_ready", 32'(ifu_req_ready), 1);
        chk("ifu.lsu_ready", 32'(lsu_req_ready), 0);
        step;
        ifu_req_valid = 1'b0;
        #1;
        chk("ifu.arvalid", 32'(bus.arvalid), 1);
        chk("ifu.araddr",  bus.araddr, a);
        chk("ifu.arlen",   32'(bus.arlen), 3);
        chk("ifu.arid",    32'(bus.arid), 0);
        chk("ifu.arsize",  32'(bus.arsize), 2);
        chk("ifu.arburst", 32'(bus.arburst), 1);
        step;
        chk("ifu.ar_hold", 32'(bus.arvalid), 1);
        chk("ifu.ar_hold_addr", bus.araddr, a);
        bus.arready = 1'b1;
        step;
        bus.arready = 1'b0;
        #1;
        chk("ifu.r_arvalid", 32'(bus.arvalid), 0);
        chk("ifu.r_rready",  32'(bus.rready), 1);
        chk("ifu.r_gap",     32'(ifu_rvalid), 0);
        for (int i = 0; i < 4; i++) begin
            step;
            bus.rvalid = 1'b1;
            bus.rdata  = 32'hA5A5_0000 + 32'(i);
            bus.rlast  = (i == 3);
            bus.rresp  = (i == err_beat) ? RESP_SLVERR : RESP_OKAY;
            #1;
            chk("ifu.beat_valid", 32'(ifu_rvalid), 1);
            chk("ifu.beat_data",  ifu_rdata, 32'hA5A5_0000 + 32'(i));
            chk("ifu.beat_last",  32'(ifu_rlast), 32'(i == 3));
            chk("ifu.beat_err",   32'(ifu_rerr), 32'(i == err_beat));
            chk("ifu.beat_lsu",   32'(lsu_rsp_valid), 0);
        end
        step;
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        bus.rresp  = RESP_OKAY;
        #1;
        quiet("ifu.end");
    endtask

    // LSU store; readies rise after the given per-channel delays.
    task automatic lsu_store(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int aw_dly,
                             input int w_dly, input logic [1:0] br);
        logic aw_hs, w_hs;
        lsu_wen       = 1'b1;
        lsu_addr      = a;
        lsu_size      = 3'd0;
        lsu_wdata     = d;
        lsu_wstrb     = s;
        lsu_req_valid = 1'b1;
        #1;
        chk("st.req_ready", 32'(lsu_req_ready), 1);
        chk("st.ifu_ready", 32'(ifu_req_ready), 0);
        step;
        lsu_req_valid = 1'b0;
        lsu_wen       = 1'b0;
        aw_hs = 1'b0;
        w_hs  = 1'b0;
        for (int c = 0; c < 10 && !(aw_hs && w_hs); c++) begin
            bus.awready = (c >= aw_dly);
            bus.wready  = (c >= w_dly);
            #1;
            chk("st.awvalid", 32'(bus.awvalid), 32'(!aw_hs));
            chk("st.wvalid",  32'(bus.wvalid), 32'(!w_hs));
            chk("st.bready",  32'(bus.bready), 0);
            if (!aw_hs) begin
                chk("st.awaddr",  bus.awaddr, a);
                chk("st.awlen",   32'(bus.awlen), 0);
                chk("st.awid",    32'(bus.awid), 1);
                chk("st.awsize",  32'(bus.awsize), 0);
                chk("st.awburst", 32'(bus.awburst), 1);
            end
            if (!w_hs) begin
                chk("st.wdata", bus.wdata, d);
                chk("st.wstrb", 32'(bus.wstrb), 32'(s));
                chk("st.wlast", 32'(bus.wlast), 1);
            end
            if (c >= aw_dly) aw_hs = 1'b1;
            if (c >= w_dly) w_hs = 1'b1;
            step;
        end
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        #1;
        chk("st.b_bready",  32'(bus.bready), 1);
        chk("st.b_awvalid", 32'(bus.awvalid), 0);
        chk("st.b_wvalid",  32'(bus.wvalid), 0);
        chk("st.b_wait",    32'(lsu_rsp_valid), 0);
        step;
        bus.bvalid = 1'b1;
        bus.bresp  = br;
        #1;
        chk("st.rsp_valid", 32'(lsu_rsp_valid), 1);
        chk("st.rsp_err",   32'(lsu_rsp_err), 32'(br[1]));
        step;
        bus.bvalid = 1'b0;
        bus.bresp  = RESP_OKAY;
        #1;
        quiet("st.end");
    endtask

    task automatic lsu_load(input logic [31:0] a, input logic [2:0] sz,
                            input logic [31:0] d, input logic [1:0] rr);
        lsu_wen       = 1'b0;
        lsu_addr      = a;
        lsu_size      = sz;
        lsu_req_valid = 1'b1;
        #1;
        chk("ld.req_ready", 32'(lsu_req_ready), 1);
        chk("ld.ifu_ready", 32'(ifu_req_ready), 0);
        step;
        lsu_req_valid = 1'b0;
        #1;
        chk("ld.arvalid", 32'(bus.arvalid), 1);
        chk("ld.arid",    32'(bus.arid), 1);
        chk("ld.arlen",   32'(bus.arlen), 0);
        chk("ld.arsize",  32'(bus.arsize), 32'(sz));
        chk("ld.araddr",  bus.araddr, a);
        chk("ld.arburst", 32'(bus.arburst), 1);
        bus.arready = 1'b1;
        step;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b1;
        bus.rdata   = d;
        bus.rlast   = 1'b1;
        bus.rresp   = rr;
        #1;
        chk("ld.rsp_valid", 32'(lsu_rsp_valid), 1);
        chk("ld.rsp_rdata", lsu_rsp_rdata, d);
        chk("ld.rsp_err",   32'(lsu_rsp_err), 32'(rr[1]));
        chk("ld.ifu_rv",    32'(ifu_rvalid), 0);
        step;
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        bus.rresp  = RESP_OKAY;
        #1;
        chk("ld.end_rsp",    32'(lsu_rsp_valid), 0);
        chk("ld.end_rready", 32'(bus.rready), 0);
    endtask

    initial begin
        reset         = 1'b1;
        ifu_req_valid = 1'b1;
        ifu_addr      = '0;
        ifu_len       = '0;
        lsu_req_valid = 1'b0;
        lsu_wen       = 1'b0;
        lsu_addr      = '0;
        lsu_size      = '0;
        lsu_wdata     = '0;
        lsu_wstrb     = '0;
        bus.awready   = 1'b0;
        bus.wready    = 1'b0;
        bus.bvalid    = 1'b0;
        bus.bid       = '0;
        bus.bresp     = '0;
        bus.arready   = 1'b0;
        bus.rvalid    = 1'b0;
        bus.rid       = '0;
        bus.rdata     = '0;
        bus.rresp     = '0;
        bus.rlast     = 1'b0;

        step;
        step;
        quiet("rst");
        chk("rst.ifu_ready", 32'(ifu_req_ready), 0);
        chk("rst.araddr",    bus.araddr, 0);
        reset         = 1'b0;
        ifu_req_valid = 1'b0;
        step;

        ifu_burst(32'h3000_0000, 4);

        lsu_store(32'h1000_0000, 32'h0000_0041, 4'h1, 0, 0, RESP_OKAY);
        lsu_store(32'h1000_0004, 32'h0000_4200, 4'h2, 3, 0, RESP_OKAY);
        lsu_store(32'h8000_0008, 32'h1234_5678, 4'hF, 0, 2, RESP_SLVERR);

        ifu_burst(32'h3000_0040, 1);

        ifu_addr      = 32'h3000_0080;
        ifu_len       = 8'd3;
        ifu_req_valid = 1'b1;
        lsu_load(32'h8000_0010, 3'd2, 32'hDEAD_BEEF, RESP_OKAY);
        chk("sim.ifu_next", 32'(ifu_req_ready), 1);
        ifu_burst(32'h3000_0080, 4);

        ifu_addr      = 32'h3000_0100;
        ifu_len       = 8'd3;
        ifu_req_valid = 1'b1;
        step;
        ifu_req_valid = 1'b0;
        bus.arready   = 1'b1;
        step;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b1;
        bus.rdata   = 32'h5555_0000;
        #1;
        chk("mid.beat1", 32'(ifu_rvalid), 1);
        step;
        bus.rvalid    = 1'b0;
        reset         = 1'b1;
        lsu_req_valid = 1'b1;
        step;
        quiet("mid");
        chk("mid.lsu_ready", 32'(lsu_req_ready), 0);
        lsu_req_valid = 1'b0;
        reset         = 1'b0;

        lsu_store(32'h1000_0000, 32'h0000_0042, 4'h1, 1, 1, RESP_OKAY);
        lsu_load(32'h8000_0020, 3'd1, 32'h0000_BEEF, RESP_SLVERR);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
